// File: rtl/phys_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : phys_wb_arbiter_pkg
// Brief  : Shared widths, write-request type and round-robin helper.
// Rev    : 1.0 - initial release
// ============================================================================
package phys_wb_arbiter_pkg;

  localparam int C_NUM_PREGS = 64;
  localparam int C_PREG_W    = $clog2(C_NUM_PREGS);
  localparam int C_DATA_W    = 32;
  localparam int C_NUM_SRC   = 3;
  localparam int C_DEPTH     = 2;

  typedef struct packed {
    logic [C_PREG_W-1:0] preg;
    logic [C_DATA_W-1:0] data;
  } wb_req_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phys_wb_arbiter_wb_src_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_src_fifo
// Brief  : Per-source result FIFO; ready is based on registered count only.
// Rev    : 1.0 - initial release
// ============================================================================
module wb_src_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ready
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  assign ready  = (r_count < C_FULL) && !flush;
  assign w_push = push && ready;
  // Popping an empty FIFO is ignored, so a same-edge push never flows through.
  assign w_pop  = pop && (r_count != '0) && !flush;
  assign head   = r_mem[r_rd_ptr];
  assign count  = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/phys_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : phys_wb_arbiter
// Brief  : Round-robin write-back arbiter for the physical register file.
// Rev    : 1.0 - initial release
// ============================================================================
module phys_wb_arbiter
  import phys_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = C_NUM_SRC,
  parameter int PREG_W  = C_PREG_W,
  parameter int DATA_W  = C_DATA_W,
  parameter int DEPTH   = C_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*PREG_W-1:0] src_preg,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      wb_update,
  output logic [PREG_W-1:0]         wb_reg,
  output logic [DATA_W-1:0]         wb_value
);

  localparam int C_REQ_W = PREG_W + DATA_W;
  localparam int C_IDX_W = $clog2(NUM_SRC);
  localparam int C_CNT_W = $clog2(DEPTH) + 1;

  logic [C_REQ_W-1:0] w_head  [NUM_SRC];
  logic [C_CNT_W-1:0] w_count [NUM_SRC];
  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_pop;
  logic               w_sel_en;
  logic               w_found;
  logic [C_IDX_W-1:0] w_winner;
  logic [C_REQ_W-1:0] w_win_req;

  logic [C_IDX_W-1:0] r_rr_ptr;
  logic               r_wb_update;
  logic [PREG_W-1:0]  r_wb_reg;
  logic [DATA_W-1:0]  r_wb_value;

  assign w_sel_en = !stall && !flush;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      wb_src_fifo #(
        .WIDTH (C_REQ_W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (src_valid[gi]),
        .push_data ({src_preg[gi*PREG_W +: PREG_W], src_data[gi*DATA_W +: DATA_W]}),
        .pop       (w_pop[gi]),
        .head      (w_head[gi]),
        .count     (w_count[gi]),
        .ready     (src_ready[gi])
      );

      assign w_empty[gi] = (w_count[gi] == '0);
      assign w_pop[gi]   = w_sel_en && w_found && (w_winner == C_IDX_W'(gi));
    end
  endgenerate

  // Scan sources starting at the round-robin pointer, wrapping around once.
  always_comb begin
    int idx;
    idx       = 0;
    w_found   = 1'b0;
    w_winner  = '0;
    w_win_req = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!w_found && !w_empty[idx]) begin
        w_found   = 1'b1;
        w_winner  = C_IDX_W'(idx);
        w_win_req = w_head[idx];
      end
    end
  end

  // Stall freezes the whole write port so the held write lands exactly once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_update <= 1'b0;
      r_wb_reg    <= '0;
      r_wb_value  <= '0;
      r_rr_ptr    <= '0;
    end else if (flush) begin
      r_wb_update <= 1'b0;
    end else if (!stall) begin
      if (w_found) begin
        r_wb_update <= 1'b1;
        r_wb_reg    <= w_win_req[C_REQ_W-1 -: PREG_W];
        r_wb_value  <= w_win_req[DATA_W-1:0];
        r_rr_ptr    <= C_IDX_W'(rr_next(int'(w_winner), NUM_SRC));
      end else begin
        r_wb_update <= 1'b0;
      end
    end
  end

  assign wb_update = r_wb_update;
  assign wb_reg    = r_wb_reg;
  assign wb_value  = r_wb_value;

endmodule
`default_nettype wire

// File: tb/tb_phys_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_phys_wb_arbiter
// Brief  : Vector table plus per-source scoreboard for phys_wb_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_phys_wb_arbiter;
  import phys_wb_arbiter_pkg::*;

  localparam int NS = 3;
  localparam int PW = 6;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stall = 1'b0;
  logic            flush = 1'b0;
  logic [NS-1:0]   src_valid = '0;
  logic [NS*PW-1:0] src_preg = '0;
  logic [NS*DW-1:0] src_data = '0;
  logic [NS-1:0]   src_ready;
  logic            wb_update;
  logic [PW-1:0]   wb_reg;
  logic [DW-1:0]   wb_value;

  typedef struct {
    logic [2:0] valid;
    logic [5:0] p0, p1, p2;
    logic       st, fl;
    logic       exp_upd;
    logic [5:0] exp_reg;
    logic [2:0] exp_rdy;
  } vec_t;

  vec_t    tbl [$];
  vec_t    cur;
  wb_req_t sbq [NS][$];
  int      n_vec  = 0;
  int      n_fail = 0;
  int      seq    = 0;

  phys_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .src_valid (src_valid),
    .src_preg  (src_preg),
    .src_data  (src_data),
    .src_ready (src_ready),
    .wb_update (wb_update),
    .wb_reg    (wb_reg),
    .wb_value  (wb_value)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] v, input int p0, input int p1, input int p2,
                              input logic st, input logic fl, input logic upd, input int rg,
                              input logic [2:0] rdy);
    vec_t t;
    t.valid = v; t.p0 = 6'(p0); t.p1 = 6'(p1); t.p2 = 6'(p2);
    t.st = st; t.fl = fl; t.exp_upd = upd; t.exp_reg = 6'(rg); t.exp_rdy = rdy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic upd, input logic [5:0] rg,
                         input logic [2:0] rdy);
    chk({name, ".wb_update"}, {31'b0, wb_update}, {31'b0, upd});
    chk({name, ".wb_reg"},    {26'b0, wb_reg},    {26'b0, rg});
    chk({name, ".src_ready"}, {29'b0, src_ready}, {29'b0, rdy});
  endtask

  function automatic int sb_total();
    return sbq[0].size() + sbq[1].size() + sbq[2].size();
  endfunction

  // One clock: drive at posedge+1, record accepted pushes, check a fresh write after the edge.
  task automatic drive_cycle(input logic [2:0] v, input logic [5:0] p0, input logic [5:0] p1,
                             input logic [5:0] p2, input logic st, input logic fl,
                             input logic [31:0] d0_ovr, input logic use_ovr);
    logic [31:0] d [NS];
    logic [2:0]  acc;
    wb_req_t     got;
    bit          hit;
    for (int i = 0; i < NS; i++) d[i] = {4'(4'hA + i), 12'h000, 16'(seq)};
    if (use_ovr) d[0] = d0_ovr;
    seq++;
    src_valid = v;
    src_preg  = {p2, p1, p0};
    src_data  = {d[2], d[1], d[0]};
    stall     = st;
    flush     = fl;
    #1;
    acc = src_valid & src_ready;
    for (int i = 0; i < NS; i++)
      if (acc[i]) sbq[i].push_back({src_preg[i*PW +: PW], d[i]});
    @(posedge clk);
    #1;
    if (fl) begin
      for (int i = 0; i < NS; i++) sbq[i].delete();
    end else if (!st && wb_update) begin
      got = {wb_reg, wb_value};
      hit = 1'b0;
      for (int i = 0; i < NS; i++) begin
        if (!hit && sbq[i].size() > 0 && sbq[i][0] == got) begin
          void'(sbq[i].pop_front());
          hit = 1'b1;
        end
      end
      n_vec++;
      if (!hit) begin
        n_fail++;
        $display("FAIL sb_write: actual tag=%0d value=%h, required head of a source queue",
                 wb_reg, wb_value);
      end
    end
  endtask

  task automatic idle(input logic st);
    drive_cycle(3'b000, 6'd0, 6'd0, 6'd0, st, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic apply_reset();
    src_valid = '0; stall = 1'b0; flush = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst.wb_update", {31'b0, wb_update}, 32'd0);
    chk("rst.wb_reg",    {26'b0, wb_reg},    32'd0);
    chk("rst.wb_value",  wb_value,           32'd0);
    for (int i = 0; i < NS; i++) sbq[i].delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.src_ready", {29'b0, src_ready}, 32'h7);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    // Continuous sequence from reset: rotation, lone source 2, stall hold, flush.
    tbl.push_back(mk(3'b111,  1,  2,  3, 0, 0, 0,  0, 3'b111));
    tbl.push_back(mk(3'b111,  1,  2,  3, 0, 0, 1,  1, 3'b001));
    tbl.push_back(mk(3'b111,  1,  2,  3, 0, 0, 1,  2, 3'b010));
    tbl.push_back(mk(3'b111,  1,  2,  3, 0, 0, 1,  3, 3'b100));
    tbl.push_back(mk(3'b111,  1,  2,  3, 0, 0, 1,  1, 3'b001));
    tbl.push_back(mk(3'b111,  1,  2,  3, 0, 0, 1,  2, 3'b010));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 1,  3, 3'b110));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 1,  1, 3'b111));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 1,  2, 3'b111));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 1,  3, 3'b111));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 1,  1, 3'b111));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 0,  1, 3'b111));
    tbl.push_back(mk(3'b100,  0,  0,  7, 0, 0, 0,  1, 3'b111));
    tbl.push_back(mk(3'b100,  0,  0,  8, 0, 0, 1,  7, 3'b111));
    tbl.push_back(mk(3'b100,  0,  0,  9, 0, 0, 1,  8, 3'b111));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 1,  9, 3'b111));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 0,  9, 3'b111));
    tbl.push_back(mk(3'b010,  0, 10,  0, 0, 0, 0,  9, 3'b111));
    tbl.push_back(mk(3'b010,  0, 11,  0, 0, 0, 1, 10, 3'b111));
    tbl.push_back(mk(3'b010,  0, 12,  0, 1, 0, 1, 10, 3'b101));
    tbl.push_back(mk(3'b000,  0,  0,  0, 1, 0, 1, 10, 3'b101));
    tbl.push_back(mk(3'b000,  0,  0,  0, 1, 0, 1, 10, 3'b101));
    tbl.push_back(mk(3'b000,  0,  0,  0, 1, 0, 1, 10, 3'b101));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 1, 11, 3'b111));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 1, 12, 3'b111));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 0, 12, 3'b111));
    tbl.push_back(mk(3'b101, 20,  0, 21, 1, 0, 0, 12, 3'b111));
    tbl.push_back(mk(3'b101, 22,  0, 23, 1, 0, 0, 12, 3'b010));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 1, 21, 3'b110));
    tbl.push_back(mk(3'b101, 24,  0, 25, 1, 0, 1, 21, 3'b010));
    tbl.push_back(mk(3'b111, 50, 51, 52, 1, 1, 0, 21, 3'b000));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 0, 21, 3'b111));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 0, 21, 3'b111));
    tbl.push_back(mk(3'b100,  0,  0, 30, 0, 0, 0, 21, 3'b111));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 1, 30, 3'b111));
    tbl.push_back(mk(3'b000,  0,  0,  0, 0, 0, 0, 30, 3'b111));

    #3;
    apply_reset();

    // Single result: two cycles from valid to write, exactly one write cycle.
    drive_cycle(3'b001, 6'd5, 6'd0, 6'd0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    chk_out("single.c1", 1'b0, 6'd0, 3'b111);
    idle(1'b0);
    chk_out("single.c2", 1'b1, 6'd5, 3'b111);
    chk("single.c2.wb_value", wb_value, 32'hDEADBEEF);
    idle(1'b0);
    chk_out("single.c3", 1'b0, 6'd5, 3'b111);
    chk("single.c3.wb_value", wb_value, 32'hDEADBEEF);

    apply_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      cur = tbl[i];
      drive_cycle(cur.valid, cur.p0, cur.p1, cur.p2, cur.st, cur.fl, 32'h0, 1'b0);
      chk_out($sformatf("vec%0d", i), cur.exp_upd, cur.exp_reg, cur.exp_rdy);
    end
    chk("table.drain", sb_total(), 32'd0);

    // Asynchronous reset with four results buffered and a write on the port.
    drive_cycle(3'b111, 6'd40, 6'd41, 6'd42, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_out("mid.m1", 1'b0, 6'd30, 3'b111);
    drive_cycle(3'b011, 6'd43, 6'd44, 6'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_out("mid.m2", 1'b0, 6'd30, 3'b100);
    idle(1'b0);
    chk_out("mid.m3", 1'b1, 6'd40, 3'b101);
    src_valid = '0;
    reset = 1'b0;
    #1;
    chk_out("mid.async", 1'b0, 6'd0, 3'b111);
    chk("mid.async.wb_value", wb_value, 32'd0);
    for (int i = 0; i < NS; i++) sbq[i].delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk_out($sformatf("mid.post%0d", i), 1'b0, 6'd0, 3'b111);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
